// File: rtl/uart_rx_param_if.sv
// Serial receive bundle: the async line in and the frame results out.
// The slave modport is the receiver's view; master is the consumer/driver side.
interface uart_rx_param_if #(
   parameter int DATA_BITS = 8
);
   logic                 recieverInput;
   logic [DATA_BITS-1:0] byteRecieved;
   logic                 done;
   logic                 parityError;
   logic                 framingError;
   logic                 busy;

   modport master (
      output recieverInput,
      input  byteRecieved, done, parityError, framingError, busy
   );

   modport slave (
      input  recieverInput,
      output byteRecieved, done, parityError, framingError, busy
   );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling, optional
// parity, 1 or 2 stop bits, one-cycle done/parity/framing pulses.
//
// state  | meaning
// IDLE   | waiting for a low line (only while armed)
// START  | counting to mid start bit to reject glitches
// DATA   | sampling DATA_BITS payload bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling stop bits, then reporting the frame
module uart_rx_param #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input logic             clk,
   input logic             rst,
   uart_rx_param_if.slave  rxIf
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic              PAR_ODD   = (PARITY_ODD != 0);
   localparam logic              PAR_EN    = (PARITY_EN != 0);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               stateCounter;
   state_t               nextState;
   logic                 sync1;
   logic                 sync2;
   logic [BAUD_W-1:0]    baudCnt;
   logic [BIT_W-1:0]     bitCnt;
   logic [DATA_BITS-1:0] shiftReg;
   logic [DATA_BITS-1:0] byteReg;
   logic                 armed;
   logic                 parFail;
   logic                 frameFail;
   logic                 frameFailNext;
   logic                 doneReg;
   logic                 parErrReg;
   logic                 frmErrReg;
   logic                 midBit;
   logic                 halfBit;

   assign midBit  = (baudCnt == BAUD_LAST);
   assign halfBit = (baudCnt == BAUD_HALF);

   always_ff @(posedge clk) begin
      if (rst) begin
         stateCounter <= IDLE;
      end else begin
         stateCounter <= nextState;
      end
   end

   always_comb begin
      nextState     = stateCounter;
      frameFailNext = frameFail;
      case (stateCounter)
         IDLE: begin
            if (armed && !sync2) nextState = START;
         end
         START: begin
            if (halfBit) nextState = sync2 ? IDLE : DATA;
         end
         DATA: begin
            if (midBit && (bitCnt == DATA_LAST)) nextState = PAR_EN ? PARITY : STOP;
         end
         PARITY: begin
            if (midBit) nextState = STOP;
         end
         STOP: begin
            if (midBit) begin
               frameFailNext = frameFail | ~sync2;
               if (bitCnt == STOP_LAST) nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         baudCnt   <= '0;
         bitCnt    <= '0;
         shiftReg  <= '0;
         byteReg   <= '0;
         armed     <= 1'b1;
         parFail   <= 1'b0;
         frameFail <= 1'b0;
         doneReg   <= 1'b0;
         parErrReg <= 1'b0;
         frmErrReg <= 1'b0;
      end else begin
         sync1     <= rxIf.recieverInput;
         sync2     <= sync1;
         doneReg   <= 1'b0;
         parErrReg <= 1'b0;
         frmErrReg <= 1'b0;
         case (stateCounter)
            IDLE: begin
               baudCnt <= '0;
               if (sync2) armed <= 1'b1;
               if (armed && !sync2) begin
                  parFail   <= 1'b0;
                  frameFail <= 1'b0;
               end
            end
            START: begin
               if (halfBit) begin
                  baudCnt <= '0;
                  bitCnt  <= '0;
               end else begin
                  baudCnt <= baudCnt + BAUD_W'(1);
               end
            end
            DATA: begin
               if (midBit) begin
                  baudCnt  <= '0;
                  shiftReg <= {sync2, shiftReg[DATA_BITS-1:1]};
                  bitCnt   <= (bitCnt == DATA_LAST) ? '0 : bitCnt + BIT_W'(1);
               end else begin
                  baudCnt <= baudCnt + BAUD_W'(1);
               end
            end
            PARITY: begin
               if (midBit) begin
                  baudCnt <= '0;
                  parFail <= (^shiftReg) ^ sync2 ^ PAR_ODD;
               end else begin
                  baudCnt <= baudCnt + BAUD_W'(1);
               end
            end
            STOP: begin
               if (midBit) begin
                  baudCnt   <= '0;
                  frameFail <= frameFailNext;
                  bitCnt    <= bitCnt + BIT_W'(1);
                  if (bitCnt == STOP_LAST) begin
                     bitCnt    <= '0;
                     byteReg   <= shiftReg;
                     doneReg   <= ~(parFail | frameFailNext);
                     parErrReg <= parFail;
                     frmErrReg <= frameFailNext;
                     // a break must be seen released before the next frame can start
                     if (frameFailNext) armed <= 1'b0;
                  end
               end else begin
                  baudCnt <= baudCnt + BAUD_W'(1);
               end
            end
            default: baudCnt <= '0;
         endcase
      end
   end

   assign rxIf.byteRecieved = byteReg;
   assign rxIf.done         = doneReg;
   assign rxIf.parityError  = parErrReg;
   assign rxIf.framingError = frmErrReg;
   assign rxIf.busy         = (stateCounter != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations driven from a
// vector table plus glitch, break, back-to-back and reset sequences.
module tb_uart_rx_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // dut0: defaults; dut1: even parity, 4 clk/bit; dut2: 7 bits, 2 stops, 4 clk/bit
   uart_rx_param_if #(.DATA_BITS(8)) if0 ();
   uart_rx_param_if #(.DATA_BITS(8)) if1 ();
   uart_rx_param_if #(.DATA_BITS(7)) if2 ();

   uart_rx_param dut0 (.clk(clk), .rst(rst), .rxIf(if0.slave));
   uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
      dut1 (.clk(clk), .rst(rst), .rxIf(if1.slave));
   uart_rx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
      dut2 (.clk(clk), .rst(rst), .rxIf(if2.slave));

   logic line [3];
   assign if0.recieverInput = line[0];
   assign if1.recieverInput = line[1];
   assign if2.recieverInput = line[2];

   logic [2:0] doneV, parV, frmV, busyV;
   logic [8:0] byteV [3];
   assign doneV    = {if2.done, if1.done, if0.done};
   assign parV     = {if2.parityError, if1.parityError, if0.parityError};
   assign frmV     = {if2.framingError, if1.framingError, if0.framingError};
   assign busyV    = {if2.busy, if1.busy, if0.busy};
   assign byteV[0] = {1'b0, if0.byteRecieved};
   assign byteV[1] = {1'b0, if1.byteRecieved};
   assign byteV[2] = {2'b00, if2.byteRecieved};

   int cfgD [3] = '{8, 8, 7};
   int cfgP [3] = '{0, 1, 0};
   int cfgS [3] = '{1, 1, 2};
   int cfgC [3] = '{16, 4, 4};

   typedef struct {
      int         dut;
      int         cyc;
      logic       d;
      logic       p;
      logic       f;
      logic [8:0] b;
   } ev_t;
   ev_t evQ [$];

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++)
         if (doneV[k] | parV[k] | frmV[k])
            evQ.push_back('{k, cyc, doneV[k], parV[k], frmV[k], byteV[k]});
   end

   int passCnt  = 0;
   int totalCnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCnt++;
      if (act === exp) passCnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic holdBit(input int k, input logic v, input int n);
      line[k] = v;
      idle(n);
   endtask

   // caller must be at posedge+1; returns aligned the same way
   task automatic sendFrame(input int k, input logic [8:0] data, input logic parBit,
                            input logic stopVal, output int c0);
      int c;
      c  = cfgC[k];
      c0 = cyc;
      holdBit(k, 1'b0, c);
      for (int i = 0; i < cfgD[k]; i++) holdBit(k, data[i], c);
      if (cfgP[k] != 0) holdBit(k, parBit, c);
      for (int i = 0; i < cfgS[k]; i++) holdBit(k, (i == cfgS[k] - 1) ? stopVal : 1'b1, c);
   endtask

   // cycle stamp of the pulse: E0 is c0+1, pulse registered at E0 + 2 + HALF + bits*CPB
   function automatic int expCyc(input int k, input int c0);
      return c0 + 3 + cfgC[k] / 2 + (cfgD[k] + cfgP[k] + cfgS[k]) * cfgC[k];
   endfunction

   task automatic checkOne(input string tag, input int k, input int c0, input logic eD,
                           input logic eP, input logic eF, input logic [8:0] eB);
      chk({tag, " events"}, evQ.size(), 1);
      if (evQ.size() > 0) begin
         chk({tag, " dut"},   evQ[0].dut, k);
         chk({tag, " cycle"}, evQ[0].cyc, expCyc(k, c0));
         chk({tag, " done"},  evQ[0].d, eD);
         chk({tag, " par"},   evQ[0].p, eP);
         chk({tag, " frm"},   evQ[0].f, eF);
         chk({tag, " byte"},  evQ[0].b, eB);
      end
      chk({tag, " busy"}, busyV[k], 1'b0);
   endtask

   typedef struct {
      int         dut;
      logic [8:0] data;
      logic       parBit;
      logic       stopVal;
      logic       expD;
      logic       expP;
      logic       expF;
      logic [8:0] expByte;
   } vec_t;
   localparam int NV = 10;
   vec_t vecs [NV];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0, c0b;
      logic busyAny;

      vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0A5};
      vecs[1] = '{0, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h000};
      vecs[2] = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0FF};
      vecs[3] = '{1, 9'h00F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h00F};
      vecs[4] = '{1, 9'h00F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h00F};
      vecs[5] = '{1, 9'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'h001};
      vecs[6] = '{1, 9'h001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h001};
      vecs[7] = '{2, 9'h055, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h055};
      vecs[8] = '{1, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h03C};
      vecs[9] = '{1, 9'h007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 9'h007};

      for (int k = 0; k < 3; k++) line[k] = 1'b1;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset byte%0d", k), byteV[k], 9'h000);
         chk($sformatf("reset done%0d", k), doneV[k], 1'b0);
         chk($sformatf("reset par%0d", k),  parV[k], 1'b0);
         chk($sformatf("reset frm%0d", k),  frmV[k], 1'b0);
         chk($sformatf("reset busy%0d", k), busyV[k], 1'b0);
      end

      for (int v = 0; v < NV; v++) begin
         evQ.delete();
         sendFrame(vecs[v].dut, vecs[v].data, vecs[v].parBit, vecs[v].stopVal, c0);
         line[vecs[v].dut] = 1'b1;
         idle(20);
         checkOne($sformatf("vec%0d", v), vecs[v].dut, c0, vecs[v].expD, vecs[v].expP,
                  vecs[v].expF, vecs[v].expByte);
      end

      // glitch: 3 low clocks enter START, rejected at the half-bit sample
      evQ.delete();
      line[0] = 1'b0;
      idle(3);
      line[0] = 1'b1;
      chk("glitch busy in START", busyV[0], 1'b1);
      idle(12);
      chk("glitch busy after", busyV[0], 1'b0);
      idle(20);
      chk("glitch no pulses", evQ.size(), 0);

      // break: stop bit low, line held low, no restart until released
      evQ.delete();
      sendFrame(0, 9'h03C, 1'b0, 1'b0, c0);
      busyAny = 1'b0;
      for (int i = 0; i < 40; i++) begin
         idle(1);
         busyAny = busyAny | busyV[0];
      end
      chk("break no START while low", busyAny, 1'b0);
      checkOne("break", 0, c0, 1'b0, 1'b0, 1'b1, 9'h03C);
      line[0] = 1'b1;
      idle(5);
      evQ.delete();
      sendFrame(0, 9'h096, 1'b0, 1'b1, c0);
      line[0] = 1'b1;
      idle(20);
      checkOne("after break", 0, c0, 1'b1, 1'b0, 1'b0, 9'h096);

      // back-to-back 7-bit frames with two stop bits
      evQ.delete();
      sendFrame(2, 9'h055, 1'b0, 1'b1, c0);
      sendFrame(2, 9'h02A, 1'b0, 1'b1, c0b);
      line[2] = 1'b1;
      idle(20);
      chk("b2b events", evQ.size(), 2);
      if (evQ.size() >= 2) begin
         chk("b2b first cycle", evQ[0].cyc, expCyc(2, c0));
         chk("b2b spacing",     evQ[1].cyc - evQ[0].cyc, 40);
         chk("b2b byte0",       evQ[0].b, 9'h055);
         chk("b2b byte1",       evQ[1].b, 9'h02A);
         chk("b2b done0",       evQ[0].d, 1'b1);
         chk("b2b done1",       evQ[1].d, 1'b1);
      end

      // reset in the middle of DATA on dut0
      evQ.delete();
      line[0] = 1'b0;
      idle(16);
      line[0] = 1'b1;
      idle(30);
      chk("middata busy", busyV[0], 1'b1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("rst busy0", busyV[0], 1'b0);
      chk("rst byte0", byteV[0], 9'h000);
      chk("rst byte2", byteV[2], 9'h000);
      idle(200);
      chk("rst no pulses", evQ.size(), 0);
      chk("rst busy idle", busyV[0], 1'b0);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule
